pool1d_stream: RTL and testbench

//   Streaming 1-D temporal pooling stage for the CNN datapath. Sits between a conv/ReLU stage and the next layer.

---
 rtl/pool1d_stream_if.sv | 13 +
 rtl/pool1d_stream.sv | 199 +++++++++++++++++++
 tb/tb_pool1d_stream.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool1d_stream_if.sv
// Valid/ready frame stream with end-of-sequence marker. The master drives the
// frame, and the slave answers with ready.
interface pool1d_stream_if #(
    parameter int W = 256
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/pool1d_stream.sv
// Streaming 1-D temporal pooling (max or floor-average) over KERNEL-frame windows
// that start every STRIDE frames. Windows never span a sequence boundary.
module pool1d_stream #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 32,
    parameter int KERNEL   = 2,
    parameter int STRIDE   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    pool1d_stream_if.slave   src,
    pool1d_stream_if.master  dst,
    output logic             drop_partial
);

    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int LOG2K   = $clog2(KERNEL);
    localparam int SUM_W   = DATA_W + LOG2K;
    localparam int CNT_W   = (KERNEL > 1) ? $clog2(KERNEL) : 1;
    localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(KERNEL - 1);
    localparam logic [CNT_W-1:0] STRIDE_LAST = CNT_W'(STRIDE - 1);

    if (KERNEL != 1 && KERNEL != 2 && KERNEL != 4 && KERNEL != 8) begin : g_bad_kernel
        $error("pool1d_stream: KERNEL must be 1, 2, 4 or 8");
    end
    if (STRIDE < 1 || STRIDE > KERNEL) begin : g_bad_stride
        $error("pool1d_stream: STRIDE must satisfy 1 <= STRIDE <= KERNEL");
    end

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STEADY = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   fill_cnt_r;
    logic [CNT_W-1:0]   stride_cnt_r;
    logic               mode_r;
    logic               out_valid_r;
    logic [FRAME_W-1:0] out_data_r;
    logic               out_last_r;
    logic               drop_r;

    logic               accept_s;
    logic               fire_s;
    logic               first_s;
    logic               mode_eff_s;
    logic [FRAME_W-1:0] result_s;
    logic [FRAME_W-1:0] window_s [KERNEL];

    assign src.ready    = !out_valid_r || dst.ready;
    assign accept_s     = src.valid && src.ready;
    assign first_s      = (state_r == FILL) && (fill_cnt_r == '0);
    // The first frame of a sequence may itself fire (KERNEL=1), so use the live mode then.
    assign mode_eff_s   = first_s ? mode : mode_r;
    assign dst.valid    = out_valid_r;
    assign dst.data     = out_data_r;
    assign dst.last     = out_last_r;
    assign drop_partial = drop_r;

    // Window is the incoming frame plus the KERNEL-1 most recent accepted frames.
    if (KERNEL > 1) begin : g_hist
        logic [FRAME_W-1:0] hist_r [KERNEL-1];

        // History shift register, advanced on every accepted frame.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < KERNEL - 1; i++) begin
                    hist_r[i] <= '0;
                end
            end else if (accept_s) begin
                hist_r[0] <= src.data;
                for (int i = 1; i < KERNEL - 1; i++) begin
                    hist_r[i] <= hist_r[i-1];
                end
            end else begin
                hist_r <= hist_r;
            end
        end

        // Assemble the pooling window, newest frame first.
        always_comb begin
            window_s[0] = src.data;
            for (int i = 1; i < KERNEL; i++) begin
                window_s[i] = hist_r[i-1];
            end
        end
    end else begin : g_pass
        assign window_s[0] = src.data;
    end

    // Per-channel signed max and floor-average over the window.
    always_comb begin
        logic signed [DATA_W-1:0] samp_v;
        logic signed [DATA_W-1:0] max_v;
        logic signed [SUM_W-1:0]  sum_v;
        result_s = '0;
        samp_v   = '0;
        max_v    = '0;
        sum_v    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            max_v = signed'(window_s[0][c*DATA_W +: DATA_W]);
            sum_v = '0;
            for (int k = 0; k < KERNEL; k++) begin
                samp_v = signed'(window_s[k][c*DATA_W +: DATA_W]);
                sum_v  = sum_v + SUM_W'(samp_v);
                if (samp_v > max_v) begin
                    max_v = samp_v;
                end else begin
                    max_v = max_v;
                end
            end
            if (mode_eff_s) begin
                result_s[c*DATA_W +: DATA_W] = DATA_W'(sum_v >>> LOG2K);
            end else begin
                result_s[c*DATA_W +: DATA_W] = max_v;
            end
        end
    end

    // Decide whether the current accept closes a window.
    always_comb begin
        fire_s = 1'b0;
        case (state_r)
            FILL:    fire_s = accept_s && (fill_cnt_r == FILL_LAST);
            STEADY:  fire_s = accept_s && (stride_cnt_r == STRIDE_LAST);
            default: fire_s = 1'b0;
        endcase
    end

    // Window FSM, mode capture and the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FILL;
            fill_cnt_r   <= '0;
            stride_cnt_r <= '0;
            mode_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_last_r   <= 1'b0;
            drop_r       <= 1'b0;
        end else begin
            drop_r <= accept_s && src.last && !fire_s;

            if (accept_s && first_s) begin
                mode_r <= mode;
            end else begin
                mode_r <= mode_r;
            end

            if (accept_s) begin
                if (src.last) begin
                    state_r      <= FILL;
                    fill_cnt_r   <= '0;
                    stride_cnt_r <= '0;
                end else begin
                    case (state_r)
                        FILL: begin
                            if (fill_cnt_r == FILL_LAST) begin
                                state_r      <= STEADY;
                                fill_cnt_r   <= '0;
                                stride_cnt_r <= '0;
                            end else begin
                                fill_cnt_r <= fill_cnt_r + CNT_W'(1);
                            end
                        end
                        STEADY: begin
                            if (stride_cnt_r == STRIDE_LAST) begin
                                stride_cnt_r <= '0;
                            end else begin
                                stride_cnt_r <= stride_cnt_r + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_r      <= FILL;
                            fill_cnt_r   <= '0;
                            stride_cnt_r <= '0;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end

            // Accept is only possible when the register is empty or draining, so no overwrite.
            if (fire_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= result_s;
                out_last_r  <= src.last;
            end else if (dst.ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_pool1d_stream.sv
// Directed bench: a K=2,S=2 instance and a K=4,S=1 instance of the pooling stage.
module tb_pool1d_stream;

    localparam int FW = 256;
    typedef logic [FW-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mode_a;
    logic mode_b;
    logic drop_a;
    logic drop_b;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pool1d_stream_if #(.W(FW)) a_src ();
    pool1d_stream_if #(.W(FW)) a_dst ();
    pool1d_stream_if #(.W(FW)) b_src ();
    pool1d_stream_if #(.W(FW)) b_dst ();

    pool1d_stream #(.DATA_W(8), .CHANNELS(32), .KERNEL(2), .STRIDE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a),
        .src(a_src), .dst(a_dst), .drop_partial(drop_a)
    );

    pool1d_stream #(.DATA_W(8), .CHANNELS(32), .KERNEL(4), .STRIDE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b),
        .src(b_src), .dst(b_dst), .drop_partial(drop_b)
    );

    // Even channels carry a, odd channels carry b.
    function automatic frame_t mk(input logic signed [7:0] a, input logic signed [7:0] b);
        frame_t f;
        f = '0;
        for (int c = 0; c < 32; c++) begin
            f[c*8 +: 8] = (c % 2 == 1) ? b : a;
        end
        return f;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        a_src.valid = 1'b0; a_src.data = '0; a_src.last = 1'b0;
        b_src.valid = 1'b0; b_src.data = '0; b_src.last = 1'b0;
        a_dst.ready = 1'b1;
        b_dst.ready = 1'b1;
        mode_a      = 1'b0;
        mode_b      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one frame to instance sel and return #1 after the accepting edge.
    task automatic push(input int sel, input frame_t d, input logic l);
        int n;
        @(negedge clk);
        if (sel == 0) begin
            a_src.valid = 1'b1; a_src.data = d; a_src.last = l;
        end else begin
            b_src.valid = 1'b1; b_src.data = d; b_src.last = l;
        end
        n = 0;
        while (((sel == 0) ? !a_src.ready : !b_src.ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++; fails++;
            $display("FAIL push_timeout sel=%0d in_ready stayed 0 for %0d cycles, required 1", sel, n);
        end
        @(posedge clk);
        #1;
        a_src.valid = 1'b0;
        b_src.valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (a_dst.valid !== 1'b0 || a_dst.data !== '0 || a_dst.last !== 1'b0 ||
            drop_a !== 1'b0 || a_src.ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_a valid=%b last=%b drop=%b ready=%b data=%h, required 0/0/0/1/0",
                     a_dst.valid, a_dst.last, drop_a, a_src.ready, a_dst.data);
        end
        tests++;
        if (b_dst.valid !== 1'b0 || b_dst.data !== '0 || b_src.ready !== 1'b1 || drop_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_b valid=%b ready=%b drop=%b data=%h, required 0/1/0/0",
                     b_dst.valid, b_src.ready, drop_b, b_dst.data);
        end
    endtask

    task automatic test_max_k2();
        do_reset();
        push(0, mk(8'sd3, 8'sd10), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b0) begin
            fails++; $display("FAIL max_first_frame out_valid=%b, required 0", a_dst.valid);
        end
        push(0, mk(-8'sd5, 8'sd20), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd3, 8'sd20) || a_dst.last !== 1'b0) begin
            fails++; $display("FAIL max_win0 valid=%b last=%b data=%h, required 1/0 %h",
                              a_dst.valid, a_dst.last, a_dst.data, mk(8'sd3, 8'sd20));
        end
        push(0, mk(8'sd7, -8'sd1), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b0) begin
            fails++; $display("FAIL max_stride_gap out_valid=%b, required 0", a_dst.valid);
        end
        push(0, mk(8'sd1, -8'sd2), 1'b1);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd7, -8'sd1) || a_dst.last !== 1'b1) begin
            fails++; $display("FAIL max_win1 valid=%b last=%b data=%h, required 1/1 %h",
                              a_dst.valid, a_dst.last, a_dst.data, mk(8'sd7, -8'sd1));
        end
    endtask

    task automatic test_avg_k2();
        do_reset();
        mode_a = 1'b1;
        push(0, mk(8'sd3, 8'h80), 1'b0);
        mode_a = 1'b0;
        push(0, mk(-8'sd5, -8'sd127), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(-8'sd1, 8'h80)) begin
            fails++; $display("FAIL avg_floor valid=%b data=%h, required 1 %h",
                              a_dst.valid, a_dst.data, mk(-8'sd1, 8'h80));
        end
        push(0, mk(8'sd7, 8'sd127), 1'b0);
        push(0, mk(8'sd1, 8'sd127), 1'b1);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd4, 8'sd127) || a_dst.last !== 1'b1) begin
            fails++; $display("FAIL avg_win1 valid=%b last=%b data=%h, required 1/1 %h",
                              a_dst.valid, a_dst.last, a_dst.data, mk(8'sd4, 8'sd127));
        end
    endtask

    task automatic test_overlap_k4();
        do_reset();
        push(1, mk(8'sd1, -8'sd1), 1'b0);
        push(1, mk(8'sd5, -8'sd2), 1'b0);
        push(1, mk(8'sd2, -8'sd3), 1'b0);
        tests++;
        if (b_dst.valid !== 1'b0) begin
            fails++; $display("FAIL k4_fill out_valid=%b after 3 frames, required 0", b_dst.valid);
        end
        push(1, mk(8'sd0, -8'sd4), 1'b0);
        tests++;
        if (b_dst.valid !== 1'b1 || b_dst.data !== mk(8'sd5, -8'sd1)) begin
            fails++; $display("FAIL k4_win0 valid=%b data=%h, required 1 %h",
                              b_dst.valid, b_dst.data, mk(8'sd5, -8'sd1));
        end
        push(1, mk(8'sd4, -8'sd5), 1'b0);
        tests++;
        if (b_dst.valid !== 1'b1 || b_dst.data !== mk(8'sd5, -8'sd2)) begin
            fails++; $display("FAIL k4_win1 valid=%b data=%h, required 1 %h",
                              b_dst.valid, b_dst.data, mk(8'sd5, -8'sd2));
        end
        push(1, mk(8'sd9, -8'sd6), 1'b1);
        tests++;
        if (b_dst.valid !== 1'b1 || b_dst.data !== mk(8'sd9, -8'sd3) || b_dst.last !== 1'b1) begin
            fails++; $display("FAIL k4_win2 valid=%b last=%b data=%h, required 1/1 %h",
                              b_dst.valid, b_dst.last, b_dst.data, mk(8'sd9, -8'sd3));
        end
        mode_b = 1'b1;
        push(1, mk(-8'sd1, 8'sd10), 1'b0);
        push(1, mk(-8'sd1, 8'sd20), 1'b0);
        push(1, mk(-8'sd1, 8'sd30), 1'b0);
        tests++;
        if (b_dst.valid !== 1'b0) begin
            fails++; $display("FAIL k4_avg_fill out_valid=%b, required 0", b_dst.valid);
        end
        push(1, mk(8'sd0, 8'sd40), 1'b1);
        tests++;
        if (b_dst.valid !== 1'b1 || b_dst.data !== mk(-8'sd1, 8'sd25) || b_dst.last !== 1'b1) begin
            fails++; $display("FAIL k4_avg valid=%b last=%b data=%h, required 1/1 %h",
                              b_dst.valid, b_dst.last, b_dst.data, mk(-8'sd1, 8'sd25));
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        a_dst.ready = 1'b0;
        push(0, mk(8'sd1, 8'sd2), 1'b0);
        push(0, mk(8'sd3, -8'sd4), 1'b0);
        @(negedge clk);
        a_src.valid = 1'b1; a_src.data = mk(8'sd5, 8'sd6); a_src.last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd3, 8'sd2) ||
                a_dst.last !== 1'b0 || a_src.ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold[%0d] valid=%b ready=%b last=%b data=%h, required 1/0/0 %h",
                                  i, a_dst.valid, a_src.ready, a_dst.last, a_dst.data, mk(8'sd3, 8'sd2));
            end
            @(negedge clk);
        end
        a_dst.ready = 1'b1;
        @(posedge clk);
        #1;
        a_src.valid = 1'b0;
        tests++;
        if (a_dst.valid !== 1'b0) begin
            fails++; $display("FAIL bp_release out_valid=%b, required 0", a_dst.valid);
        end
        push(0, mk(-8'sd7, 8'sd8), 1'b1);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd5, 8'sd8) || a_dst.last !== 1'b1) begin
            fails++; $display("FAIL bp_resume valid=%b last=%b data=%h, required 1/1 %h",
                              a_dst.valid, a_dst.last, a_dst.data, mk(8'sd5, 8'sd8));
        end
    endtask

    task automatic test_partial_drop();
        do_reset();
        push(0, mk(8'sd1, 8'sd1), 1'b0);
        push(0, mk(8'sd2, 8'sd2), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd2, 8'sd2) || a_dst.last !== 1'b0) begin
            fails++; $display("FAIL part_win valid=%b last=%b data=%h, required 1/0 %h",
                              a_dst.valid, a_dst.last, a_dst.data, mk(8'sd2, 8'sd2));
        end
        push(0, mk(8'sd3, 8'sd3), 1'b1);
        tests++;
        if (a_dst.valid !== 1'b0 || drop_a !== 1'b1) begin
            fails++; $display("FAIL part_drop valid=%b drop=%b, required 0/1", a_dst.valid, drop_a);
        end
        @(posedge clk);
        #1;
        tests++;
        if (drop_a !== 1'b0) begin
            fails++; $display("FAIL part_drop_pulse drop=%b one cycle later, required 0", drop_a);
        end
        push(0, mk(8'sd4, -8'sd4), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b0) begin
            fails++; $display("FAIL part_newseq_fill out_valid=%b, required 0", a_dst.valid);
        end
        push(0, mk(-8'sd6, 8'sd5), 1'b1);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd4, 8'sd5) || a_dst.last !== 1'b1 || drop_a !== 1'b0) begin
            fails++; $display("FAIL part_seq2 valid=%b last=%b drop=%b data=%h, required 1/1/0 %h",
                              a_dst.valid, a_dst.last, drop_a, a_dst.data, mk(8'sd4, 8'sd5));
        end
    endtask

    task automatic test_midreset();
        do_reset();
        push(0, mk(8'sd9, 8'sd9), 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (a_dst.valid !== 1'b0 || a_dst.data !== '0 || a_dst.last !== 1'b0 ||
            drop_a !== 1'b0 || a_src.ready !== 1'b1) begin
            fails++; $display("FAIL midreset valid=%b last=%b drop=%b ready=%b data=%h, required 0/0/0/1/0",
                              a_dst.valid, a_dst.last, drop_a, a_src.ready, a_dst.data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(0, mk(8'sd1, 8'sd2), 1'b0);
        tests++;
        if (a_dst.valid !== 1'b0) begin
            fails++; $display("FAIL midreset_refill out_valid=%b after 1 frame, required 0", a_dst.valid);
        end
        push(0, mk(8'sd3, 8'sd1), 1'b1);
        tests++;
        if (a_dst.valid !== 1'b1 || a_dst.data !== mk(8'sd3, 8'sd2) || a_dst.last !== 1'b1) begin
            fails++; $display("FAIL midreset_win valid=%b last=%b data=%h, required 1/1 %h",
                              a_dst.valid, a_dst.last, a_dst.data, mk(8'sd3, 8'sd2));
        end
    endtask

    initial begin
        test_reset();
        test_max_k2();
        test_avg_k2();
        test_overlap_k4();
        test_backpressure();
        test_partial_drop();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
